// File: rtl/wvb_wr_ctrl_ring.sv
// Waveform buffer write controller for a circular buffer shared with a reader.
// Accepts a trigger only when the nominal event fits, extends on retrigger and ends on max length or full.
module wvb_wr_ctrl_ring #(
  parameter int P_ADR_WIDTH     = 12,
  parameter int P_LTC_WIDTH     = 48,
  parameter int P_PRE_WIDTH     = 5,
  parameter int P_POST_WIDTH    = 8,
  parameter int P_HOLDOFF_WIDTH = 8,
  parameter int P_DROP_WIDTH    = 16
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic                       trig,
  input  logic [1:0]                 trig_src,
  input  logic [P_LTC_WIDTH-1:0]     ltc,
  input  logic                       trig_mode,
  input  logic                       arm,
  input  logic [P_PRE_WIDTH-1:0]     pre_config,
  input  logic [P_POST_WIDTH-1:0]    post_config,
  input  logic [P_ADR_WIDTH-1:0]     max_len_config,
  input  logic [P_HOLDOFF_WIDTH-1:0] holdoff_config,
  input  logic [P_ADR_WIDTH-1:0]     rd_addr,
  output logic [P_ADR_WIDTH-1:0]     wvb_wr_addr,
  output logic                       wvb_wren,
  output logic                       hdr_wren,
  output logic [P_ADR_WIDTH-1:0]     hdr_start_addr,
  output logic [P_ADR_WIDTH-1:0]     hdr_stop_addr,
  output logic [P_ADR_WIDTH-1:0]     hdr_evt_len,
  output logic [P_LTC_WIDTH-1:0]     hdr_ltc,
  output logic [1:0]                 hdr_trig_src,
  output logic                       hdr_trunc,
  output logic                       hdr_full,
  output logic                       armed,
  output logic                       busy,
  output logic [P_DROP_WIDTH-1:0]    drop_cnt
);

  // Lengths carry one extra bit so pre+post and the all-ones default never overflow.
  localparam int LW = P_ADR_WIDTH + 1;
  localparam logic [P_ADR_WIDTH-1:0]     ONE_A  = {{(P_ADR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0]              ONE_L  = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0]              MAX_L  = {1'b0, {P_ADR_WIDTH{1'b1}}};
  localparam logic [P_HOLDOFF_WIDTH-1:0] ONE_H  = {{(P_HOLDOFF_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [P_DROP_WIDTH-1:0]    DROP_MAX = {P_DROP_WIDTH{1'b1}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACQ = 2'd1, S_HOLDOFF = 2'd2} state_t;

  state_t                     state_reg, state_next;
  logic [P_ADR_WIDTH-1:0]     addr_reg;
  logic [P_ADR_WIDTH-1:0]     start_reg;
  logic [P_ADR_WIDTH-1:0]     len_reg;
  logic [LW-1:0]              rem_reg;
  logic [LW-1:0]              l0_reg;
  logic [LW-1:0]              maxlen_reg;
  logic [P_LTC_WIDTH-1:0]     ltc_reg;
  logic [1:0]                 src_reg;
  logic [P_HOLDOFF_WIDTH-1:0] hold_cnt_reg;
  logic                       armed_reg;
  logic [P_DROP_WIDTH-1:0]    drop_reg;

  logic [P_ADR_WIDTH-1:0] free;
  logic [LW-1:0]          pre_cfg, post_cfg, l0_cfg, mlc_cfg, maxlen_cfg;
  logic [LW-1:0]          len_inc, rem_dec, rem_ret;
  logic                   st_idle, st_acq, st_hold;
  logic                   trig_en, fits, accept, drop_any;
  logic                   hit_trunc, hit_full, natural_end, final_w;

  assign free = rd_addr - addr_reg - ONE_A;

  assign pre_cfg    = (pre_config == '0)  ? ONE_L : LW'(pre_config);
  assign post_cfg   = (post_config == '0) ? ONE_L : LW'(post_config);
  assign l0_cfg     = pre_cfg + post_cfg;
  assign mlc_cfg    = (max_len_config == '0) ? MAX_L : {1'b0, max_len_config};
  assign maxlen_cfg = (mlc_cfg < l0_cfg) ? l0_cfg : mlc_cfg;

  assign st_idle = (state_reg == S_IDLE);
  assign st_acq  = (state_reg == S_ACQ);
  assign st_hold = (state_reg == S_HOLDOFF);

  assign trig_en  = trig && (!trig_mode || armed_reg);
  assign fits     = ({1'b0, free} >= l0_cfg);
  assign accept   = st_idle && trig_en && fits;
  assign drop_any = (st_idle && trig_en && !fits) || (st_hold && trig);

  assign len_inc = {1'b0, len_reg} + ONE_L;
  assign rem_dec = rem_reg - ONE_L;
  // A retrigger restarts the post window but never shortens what is already pending.
  assign rem_ret = (rem_dec < (l0_reg - ONE_L)) ? (l0_reg - ONE_L) : rem_dec;

  assign hit_trunc   = st_acq && (len_inc == maxlen_reg);
  assign hit_full    = st_acq && (free == ONE_A);
  assign natural_end = st_acq && !trig && (rem_reg == ONE_L);
  assign final_w     = natural_end || hit_trunc || hit_full;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) state_next = S_ACQ;
      end
      S_ACQ: begin
        if (final_w) state_next = (holdoff_config != '0) ? S_HOLDOFF : S_IDLE;
      end
      S_HOLDOFF: begin
        if (hold_cnt_reg == ONE_H) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    wvb_wren       = accept || st_acq;
    hdr_wren       = final_w;
    hdr_trunc      = hit_trunc;
    hdr_full       = hit_full;
    hdr_stop_addr  = final_w ? addr_reg : '0;
    hdr_evt_len    = final_w ? len_inc[P_ADR_WIDTH-1:0] : '0;
    hdr_start_addr = start_reg;
    hdr_ltc        = ltc_reg;
    hdr_trig_src   = src_reg;
    busy           = !st_idle;
    armed          = armed_reg;
    drop_cnt       = drop_reg;
    wvb_wr_addr    = addr_reg;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      addr_reg     <= '0;
      start_reg    <= '0;
      len_reg      <= '0;
      rem_reg      <= '0;
      l0_reg       <= '0;
      maxlen_reg   <= '0;
      ltc_reg      <= '0;
      src_reg      <= '0;
      hold_cnt_reg <= '0;
      armed_reg    <= 1'b0;
      drop_reg     <= '0;
    end else begin
      if (wvb_wren) addr_reg <= addr_reg + ONE_A;

      // Config is only sampled while idle so an event runs with a stable length.
      if (st_idle) begin
        l0_reg     <= l0_cfg;
        maxlen_reg <= maxlen_cfg;
      end

      if (accept) begin
        start_reg <= addr_reg;
        ltc_reg   <= ltc;
        src_reg   <= trig_src;
        rem_reg   <= l0_cfg - ONE_L;
        len_reg   <= ONE_A;
      end else if (st_acq) begin
        len_reg <= len_inc[P_ADR_WIDTH-1:0];
        rem_reg <= trig ? rem_ret : rem_dec;
      end

      if (final_w) begin
        hold_cnt_reg <= holdoff_config;
      end else if (st_hold) begin
        hold_cnt_reg <= hold_cnt_reg - ONE_H;
      end

      if (arm) begin
        armed_reg <= 1'b1;
      end else if (final_w) begin
        armed_reg <= 1'b0;
      end

      if (drop_any && (drop_reg != DROP_MAX)) drop_reg <= drop_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_wvb_wr_ctrl_ring.sv
// Directed bench for wvb_wr_ctrl_ring: single events, retrigger, truncation, full, wrap, holdoff, drops, arming.
module tb_wvb_wr_ctrl_ring;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        trig;
  logic [1:0]  trig_src;
  logic [47:0] ltc;
  logic        trig_mode;
  logic        arm;
  logic [4:0]  pre_config;
  logic [7:0]  post_config;
  logic [11:0] max_len_config;
  logic [7:0]  holdoff_config;
  logic [11:0] rd_addr;
  logic [11:0] wvb_wr_addr;
  logic        wvb_wren;
  logic        hdr_wren;
  logic [11:0] hdr_start_addr;
  logic [11:0] hdr_stop_addr;
  logic [11:0] hdr_evt_len;
  logic [47:0] hdr_ltc;
  logic [1:0]  hdr_trig_src;
  logic        hdr_trunc;
  logic        hdr_full;
  logic        armed;
  logic        busy;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  // Captured event results
  int          nwr;
  bit          got_hdr;
  logic [11:0] addr_log [0:15];
  logic [11:0] c_start, c_stop, c_len;
  logic [47:0] c_ltc;
  logic [1:0]  c_src;
  logic        c_trunc, c_full;

  always #5 clk = ~clk;

  wvb_wr_ctrl_ring dut (
    .clk(clk), .i_rst(i_rst), .trig(trig), .trig_src(trig_src), .ltc(ltc),
    .trig_mode(trig_mode), .arm(arm), .pre_config(pre_config), .post_config(post_config),
    .max_len_config(max_len_config), .holdoff_config(holdoff_config), .rd_addr(rd_addr),
    .wvb_wr_addr(wvb_wr_addr), .wvb_wren(wvb_wren), .hdr_wren(hdr_wren),
    .hdr_start_addr(hdr_start_addr), .hdr_stop_addr(hdr_stop_addr), .hdr_evt_len(hdr_evt_len),
    .hdr_ltc(hdr_ltc), .hdr_trig_src(hdr_trig_src), .hdr_trunc(hdr_trunc), .hdr_full(hdr_full),
    .armed(armed), .busy(busy), .drop_cnt(drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; trig = 1'b0; arm = 1'b0; trig_mode = 1'b0;
    trig_src = 2'd0; ltc = 48'd0; rd_addr = 12'd0;
    pre_config = 5'd4; post_config = 8'd6; max_len_config = 12'd0; holdoff_config = 8'd0;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  // Fires a trigger on cycle 1, optional retrigger (retrig_at<0 means every cycle), captures until hdr_wren.
  task automatic run_event(input int retrig_at, input int max_cyc);
    int cyc;
    nwr = 0; got_hdr = 1'b0; cyc = 0;
    while (!got_hdr && cyc < max_cyc) begin
      cyc++;
      trig = (cyc == 1) || (retrig_at < 0) || (cyc == retrig_at);
      #4;
      if (wvb_wren) begin
        if (nwr < 16) addr_log[nwr] = wvb_wr_addr;
        nwr++;
      end
      if (hdr_wren) begin
        got_hdr = 1'b1;
        c_start = hdr_start_addr; c_stop = hdr_stop_addr; c_len = hdr_evt_len;
        c_ltc = hdr_ltc; c_src = hdr_trig_src; c_trunc = hdr_trunc; c_full = hdr_full;
      end
      @(posedge clk);
      #1;
    end
    trig = 1'b0;
    checks++;
    if (!got_hdr) begin
      errors++;
      $display("FAIL event_timeout: no hdr_wren within %0d cycles, writes=%0d", max_cyc, nwr);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #4;
    checks++;
    if ({wvb_wr_addr, wvb_wren, hdr_wren, busy, armed, drop_cnt, hdr_start_addr, hdr_evt_len, hdr_ltc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%0d wren=%b hdr=%b busy=%b armed=%b drop=%0d start=%0d len=%0d ltc=%0h, all required 0",
               wvb_wr_addr, wvb_wren, hdr_wren, busy, armed, drop_cnt, hdr_start_addr, hdr_evt_len, hdr_ltc);
    end
    $display("test_reset done");
    tick();
  endtask

  task automatic test_single();
    do_reset();
    ltc = 48'h1234_5678_9ABC; trig_src = 2'd2;
    run_event(0, 40);
    checks++;
    if ({nwr[7:0], c_start, c_stop, c_len, c_trunc, c_full} !== {8'd10, 12'd0, 12'd9, 12'd10, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_hdr: writes=%0d start=%0d stop=%0d len=%0d trunc=%b full=%b, required 10 0 9 10 0 0",
               nwr, c_start, c_stop, c_len, c_trunc, c_full);
    end
    checks++;
    if (c_ltc !== 48'h1234_5678_9ABC || c_src !== 2'd2 || addr_log[3] !== 12'd3) begin
      errors++;
      $display("FAIL single_latch: ltc=%0h src=%0d addr3=%0d, required 123456789abc 2 3", c_ltc, c_src, addr_log[3]);
    end
    #4;
    checks++;
    if (wvb_wren !== 1'b0 || busy !== 1'b0 || wvb_wr_addr !== 12'd10) begin
      errors++;
      $display("FAIL single_after: wren=%b busy=%b addr=%0d, required 0 0 10", wvb_wren, busy, wvb_wr_addr);
    end
    $display("test_single writes=%0d len=%0d", nwr, c_len);
    tick();
  endtask

  task automatic test_retrig();
    do_reset();
    run_event(4, 40);
    checks++;
    if ({nwr[7:0], c_stop, c_len, c_trunc} !== {8'd13, 12'd12, 12'd13, 1'b0}) begin
      errors++;
      $display("FAIL retrig_hdr: writes=%0d stop=%0d len=%0d trunc=%b, required 13 12 13 0", nwr, c_stop, c_len, c_trunc);
    end
    $display("test_retrig writes=%0d len=%0d", nwr, c_len);
  endtask

  task automatic test_trunc();
    do_reset();
    max_len_config = 12'd12;
    run_event(4, 40);
    checks++;
    if ({nwr[7:0], c_stop, c_len, c_trunc, c_full} !== {8'd12, 12'd11, 12'd12, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL trunc_hdr: writes=%0d stop=%0d len=%0d trunc=%b full=%b, required 12 11 12 1 0",
               nwr, c_stop, c_len, c_trunc, c_full);
    end
    $display("test_trunc writes=%0d len=%0d", nwr, c_len);
  endtask

  task automatic test_drop_nofit();
    do_reset();
    rd_addr = 12'd5;
    trig = 1'b1;
    #4;
    checks++;
    if (wvb_wren !== 1'b0) begin
      errors++;
      $display("FAIL nofit_wren: wren=%b, required 0", wvb_wren);
    end
    tick();
    trig = 1'b0;
    #4;
    checks++;
    if (drop_cnt !== 16'd1 || busy !== 1'b0 || wvb_wr_addr !== 12'd0) begin
      errors++;
      $display("FAIL nofit_drop: drop=%0d busy=%b addr=%0d, required 1 0 0", drop_cnt, busy, wvb_wr_addr);
    end
    $display("test_drop_nofit drop=%0d", drop_cnt);
    tick();
  endtask

  task automatic test_full();
    do_reset();
    rd_addr = 12'd11;
    run_event(5, 40);
    checks++;
    if ({nwr[7:0], c_stop, c_len, c_trunc, c_full} !== {8'd10, 12'd9, 12'd10, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL full_hdr: writes=%0d stop=%0d len=%0d trunc=%b full=%b, required 10 9 10 0 1",
               nwr, c_stop, c_len, c_trunc, c_full);
    end
    $display("test_full writes=%0d len=%0d", nwr, c_len);
  endtask

  task automatic test_wrap();
    do_reset();
    max_len_config = 12'd4090;
    run_event(-1, 5000);
    checks++;
    if ({c_len, c_stop, c_trunc, wvb_wr_addr} !== {12'd4090, 12'd4089, 1'b1, 12'd4090}) begin
      errors++;
      $display("FAIL wrap_fill: len=%0d stop=%0d trunc=%b addr=%0d, required 4090 4089 1 4090",
               c_len, c_stop, c_trunc, wvb_wr_addr);
    end
    rd_addr = 12'd4; pre_config = 5'd4; post_config = 8'd4; max_len_config = 12'd0;
    run_event(0, 40);
    checks++;
    if ({nwr[7:0], c_start, c_stop, c_len, c_full} !== {8'd8, 12'd4090, 12'd1, 12'd8, 1'b0}) begin
      errors++;
      $display("FAIL wrap_hdr: writes=%0d start=%0d stop=%0d len=%0d full=%b, required 8 4090 1 8 0",
               nwr, c_start, c_stop, c_len, c_full);
    end
    checks++;
    if (addr_log[5] !== 12'd4095 || addr_log[6] !== 12'd0) begin
      errors++;
      $display("FAIL wrap_addr: addr5=%0d addr6=%0d, required 4095 0", addr_log[5], addr_log[6]);
    end
    $display("test_wrap writes=%0d stop=%0d", nwr, c_stop);
  endtask

  task automatic test_holdoff();
    logic [15:0] d0;
    bit          seen;
    do_reset();
    holdoff_config = 8'd5;
    run_event(0, 40);
    d0 = drop_cnt;
    for (int k = 1; k <= 5; k++) begin
      trig = 1'b1;
      #4;
      checks++;
      if (wvb_wren !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL holdoff_cycle%0d: wren=%b busy=%b, required 0 1", k, wvb_wren, busy);
      end
      tick();
    end
    #4;
    checks++;
    if (wvb_wren !== 1'b1 || drop_cnt !== d0 + 16'd5) begin
      errors++;
      $display("FAIL holdoff_accept: wren=%b drop=%0d, required 1 %0d", wvb_wren, drop_cnt, d0 + 16'd5);
    end
    tick();
    trig = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      #4;
      seen = hdr_wren;
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL holdoff_second_event: hdr_wren=0, required 1");
    end
    $display("test_holdoff drop=%0d", drop_cnt);
  endtask

  task automatic test_armed();
    logic [15:0] d0;
    do_reset();
    trig_mode = 1'b1;
    d0 = drop_cnt;
    trig = 1'b1;
    #4;
    checks++;
    if (wvb_wren !== 1'b0) begin
      errors++;
      $display("FAIL unarmed_wren: wren=%b, required 0", wvb_wren);
    end
    tick();
    trig = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    #4;
    checks++;
    if (drop_cnt !== d0 || armed !== 1'b1) begin
      errors++;
      $display("FAIL unarmed_drop: drop=%0d armed=%b, required %0d 1", drop_cnt, armed, d0);
    end
    tick();
    run_event(0, 40);
    checks++;
    if (nwr !== 10 || armed !== 1'b0) begin
      errors++;
      $display("FAIL armed_event: writes=%0d armed=%b, required 10 0", nwr, armed);
    end
    $display("test_armed writes=%0d", nwr);
  endtask

  task automatic test_reset_mid_event();
    bit seen;
    do_reset();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    tick();
    i_rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #4;
      if (hdr_wren) seen = 1'b1;
      tick();
      i_rst = 1'b0;
    end
    checks++;
    if (seen || busy !== 1'b0 || wvb_wr_addr !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid: hdr_seen=%b busy=%b addr=%0d, required 0 0 0", seen, busy, wvb_wr_addr);
    end
    $display("test_reset_mid_event addr=%0d", wvb_wr_addr);
  endtask

  initial begin
    test_reset();
    test_single();
    test_retrig();
    test_trunc();
    test_drop_nofit();
    test_full();
    test_wrap();
    test_holdoff();
    test_armed();
    test_reset_mid_event();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wvb_wr_ctrl_ring.md
Name: wvb_wr_ctrl_ring

Overview:
- Next-generation mDOM waveform buffer write controller. It drives write address and write enable into a circular waveform buffer of depth 2^P_ADR_WIDTH, and emits one header write per event.
- New over the previous generation:
  - Tracks the reader's pointer and accepts triggers only when the whole nominal event fits.
  - Extends events on retrigger, truncates at a programmable maximum length, and ends events cleanly on buffer-full. No sticky lock-up.
  - Programmable post-event holdoff.
  - Counts dropped triggers.
- Sits between the discriminator/trigger logic and the waveform buffer + header FIFO. Sample data is pre-delayed externally by pre_config.

Parameters:
- P_ADR_WIDTH, 12, buffer address width; depth 2^P_ADR_WIDTH.
- P_LTC_WIDTH, 48, local time counter width.
- P_PRE_WIDTH, 5, pre-trigger length config width.
- P_POST_WIDTH, 8, post-trigger length config width.
- P_HOLDOFF_WIDTH, 8, holdoff config width.
- P_DROP_WIDTH, 16, dropped-trigger counter width.

Ports:
- clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- trig  in  1  trigger pulse, one cycle per trigger.
- trig_src  in  2  trigger source, latched at event start.
- ltc  in  P_LTC_WIDTH  local time, latched at event start.
- trig_mode  in  1  0 = free-running; 1 = armed single-shot.
- arm  in  1  arm request (mode 1).
- pre_config  in  P_PRE_WIDTH  pre-trigger samples.
- post_config  in  P_POST_WIDTH  post-trigger samples.
- max_len_config  in  P_ADR_WIDTH  maximum event length; 0 = 2^P_ADR_WIDTH-1.
- holdoff_config  in  P_HOLDOFF_WIDTH  dead cycles after event end.
- rd_addr  in  P_ADR_WIDTH  reader's next read address (buffer tail).
- wvb_wr_addr  out  P_ADR_WIDTH  buffer write address.
- wvb_wren  out  1  buffer write enable (combinational).
- hdr_wren  out  1  header write strobe, asserted on the final sample write.
- hdr_start_addr  out  P_ADR_WIDTH  address of first sample.
- hdr_stop_addr  out  P_ADR_WIDTH  address of last sample (= wvb_wr_addr on hdr_wren cycle).
- hdr_evt_len  out  P_ADR_WIDTH  samples written in event.
- hdr_ltc  out  P_LTC_WIDTH  latched ltc.
- hdr_trig_src  out  2  latched trig_src.
- hdr_trunc  out  1  event ended by max length.
- hdr_full  out  1  event ended by buffer full.
- armed  out  1  mode-1 armed flag.
- busy  out  1  fsm != S_IDLE.
- drop_cnt  out  P_DROP_WIDTH  dropped-trigger count, saturating.

Behaviour:
- Reset:
  - All outputs 0; fsm = S_IDLE; wvb_wr_addr = 0.
  - i_rst mid-event abandons the event with no hdr_wren.
- Free space: free = (rd_addr - wvb_wr_addr - 1) mod 2^P_ADR_WIDTH, evaluated combinationally every cycle.
- Config latch in S_IDLE only:
  - pre = max(pre_config, 1); post = max(post_config, 1); L0 = pre + post.
  - maxlen = max(max_len_config or 2^P_ADR_WIDTH-1 if 0, L0).
- Trigger accept, in S_IDLE when trig && (trig_mode==0 || armed):
  - If free >= L0: wvb_wren=1 the same cycle; latch start addr, ltc, trig_src; rem <= L0-1; len <= 1; go to S_ACQ.
  - Otherwise drop: drop_cnt++, no write.
  - In mode 1 with armed=0, trig is ignored and not counted.
- S_ACQ, one write per cycle:
  - wvb_wren=1 every cycle; len++ per write.
  - Retrigger (trig this cycle): rem_next = max(rem-1, L0-1); not final.
  - Otherwise final when rem==1, and rem_next = rem-1.
  - Forced final when len+1 == maxlen: hdr_trunc=1.
  - Forced final when free == 1 on a write cycle: hdr_full=1.
  - Both flags may be set together. A retrigger does not prevent a forced final.
- Final write:
  - hdr_wren=1 together with the last wvb_wren; header outputs valid that cycle; hdr_evt_len = len including this write.
  - Next state: S_HOLDOFF if holdoff_config != 0, else S_IDLE.
  - A trig on the cycle after hdr_wren is evaluated as a new accept in S_IDLE.
- S_HOLDOFF: counts holdoff_config cycles, then S_IDLE. Every trig in this state increments drop_cnt.
- Address: wvb_wr_addr increments mod 2^P_ADR_WIDTH after every write; wrap is seamless.
- armed: set by arm; cleared on hdr_wren. arm on the same cycle as hdr_wren wins (armed=1).
- drop_cnt saturates at all-ones.

Test Plan:
- pre=4, post=6, holdoff=0, rd_addr=0, wr_addr=0, single trig -> 10 writes to addr 0..9; hdr_wren on 10th; start=0, stop=9, len=10, trunc=0, full=0.
- Same config, extra trig on 4th write -> 13 writes; len=13; stop=12.
- As previous with max_len=12 -> 12 writes; hdr_trunc=1; len=12.
- wr_addr=0, rd_addr=5 (free=4), trig -> no write; drop_cnt=1.
- free=10 at accept, retrig on 5th write -> 10 writes; hdr_full=1; len=10. Wrap case: start wr_addr=4090 (start=4090), rd_addr=4 (free=9), pre=4, post=4, single trig -> 8 writes wrapping 4095->0 (addresses 4090..4095, 0, 1); stop=1; hdr_full=0.
- holdoff=5 -> trigs 1..5 cycles after hdr_wren drop (drop_cnt+=5); trig at cycle 6 is accepted. Mode 1 with armed=0: trig ignored, drop_cnt unchanged.
